// File: rtl/expand_accum_relu_pkg.sv
// Shared constants, FSM encoding and lane-slicing helpers for the expand
// convolution accumulate / bias / ReLU / requantise stage.
package expand_accum_relu_pkg;

   localparam int LANE_W     = 12;
   localparam int ACC_W      = 22;
   localparam int BIAS_W     = 16;
   localparam int N_LANES    = 4;
   localparam int FIFO_W     = LANE_W * N_LANES;
   localparam int BIAS_BUS_W = BIAS_W * N_LANES;
   localparam int Q_W        = 8;
   localparam int OUT_W      = 2 * N_LANES * Q_W;
   localparam int CH_W       = 11;
   localparam int GRP_W      = 12;
   localparam int SHIFT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_BIAS  = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      BP_REQ  = 2'd0,
      BP_WAIT = 2'd1,
      BP_LOAD = 2'd2
   } bias_phase_e;

   // Lane k of a FIFO word, sign-extended to accumulator width.
   function automatic logic signed [ACC_W-1:0] lane_sext(
      input logic [FIFO_W-1:0] word,
      input int                k
   );
      logic [LANE_W-1:0] v;
      v = word[k*LANE_W +: LANE_W];
      return {{(ACC_W-LANE_W){v[LANE_W-1]}}, v};
   endfunction

   function automatic logic signed [BIAS_W-1:0] bias_lane(
      input logic [BIAS_BUS_W-1:0] word,
      input int                    k
   );
      return word[k*BIAS_W +: BIAS_W];
   endfunction

endpackage

// File: rtl/expand_accum_relu_lane_requant.sv
// One output lane: accumulator + bias, ReLU, arithmetic right shift and
// saturation to uint8, captured into a holding register on load_i.
module exp_lane_requant
   import expand_accum_relu_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     load_i,
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic signed [BIAS_W-1:0] bias_i,
   input  logic [SHIFT_W-1:0]       shift_i,
   output logic [Q_W-1:0]           q_o
);

   localparam int SUM_W = ACC_W + 1;

   logic signed [SUM_W-1:0] w_sum;
   logic [SUM_W-1:0]        w_relu;
   logic [SUM_W-1:0]        w_shifted;
   logic [Q_W-1:0]          w_sat;
   logic [Q_W-1:0]          r_q;

   // Bias add, ReLU clamp, shift and saturate for the current accumulator value.
   always_comb begin
      w_sum = {acc_i[ACC_W-1], acc_i} + {{(SUM_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
      if (w_sum[SUM_W-1]) begin
         w_relu = {SUM_W{1'b0}};
      end else begin
         w_relu = w_sum;
      end
      w_shifted = w_relu >> shift_i;
      if (|w_shifted[SUM_W-1:Q_W]) begin
         w_sat = 8'hFF;
      end else begin
         w_sat = w_shifted[Q_W-1:0];
      end
   end

   // Holding register keeps the byte stable while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_q <= 8'h00;
      end else if (clr_i) begin
         r_q <= 8'h00;
      end else if (load_i) begin
         r_q <= w_sat;
      end else begin
         r_q <= r_q;
      end
   end

   assign q_o = r_q;

endmodule

// File: rtl/expand_accum_relu.sv
// Pops the 3x3 and 1x1 expand partial-sum FIFOs in lock-step, accumulates
// over the input channels, then emits biased, ReLU'd, requantised bytes.
module expand_accum_relu
   import expand_accum_relu_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [9:0]            in_ch_limit_i,
   input  logic [GRP_W-1:0]      group_limit_i,
   input  logic [SHIFT_W-1:0]    shift_i,
   input  logic [FIFO_W-1:0]     fifo_exp_3x3_rd_data_i,
   output logic                  fifo_exp_3x3_rd_en_o,
   input  logic                  fifo_exp_3x3_empty_i,
   input  logic [FIFO_W-1:0]     fifo_exp_1x1_rd_data_i,
   output logic                  fifo_exp_1x1_rd_en_o,
   input  logic                  fifo_exp_1x1_empty_i,
   output logic                  bias_req_o,
   input  logic                  bias_ready_i,
   input  logic [BIAS_BUS_W-1:0] bias_3x3_data_i,
   input  logic [BIAS_BUS_W-1:0] bias_1x1_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [OUT_W-1:0]      out_data_o,
   output logic                  done_o
);

   state_e                  r_state;
   bias_phase_e             r_bphase;
   logic [CH_W-1:0]         r_in_ch;
   logic [CH_W-1:0]         r_pops;
   logic [CH_W-1:0]         r_acc_cnt;
   logic [GRP_W-1:0]        r_group_lim;
   logic [GRP_W-1:0]        r_group;
   logic [SHIFT_W-1:0]      r_shift;
   logic                    r_pop_d;
   logic                    r_bias_req;
   logic                    r_out_valid;
   logic                    r_done;
   logic signed [ACC_W-1:0] r_acc_3x3 [N_LANES];
   logic signed [ACC_W-1:0] r_acc_1x1 [N_LANES];

   logic                    w_rd_en;
   logic                    w_lane_load;
   logic                    w_lane_clr;
   logic [Q_W-1:0]          w_q_3x3 [N_LANES];
   logic [Q_W-1:0]          w_q_1x1 [N_LANES];
   logic [OUT_W-1:0]        w_out_data;

   // Pop both FIFOs together only while accumulating, both have data and channels remain.
   always_comb begin
      if (rst_i || start_i) begin
         w_rd_en = 1'b0;
      end else if ((r_state == ST_ACCUM) && !fifo_exp_3x3_empty_i &&
                   !fifo_exp_1x1_empty_i && (r_pops < r_in_ch)) begin
         w_rd_en = 1'b1;
      end else begin
         w_rd_en = 1'b0;
      end
   end

   assign w_lane_load = (r_state == ST_BIAS) && (r_bphase == BP_LOAD);
   assign w_lane_clr  = start_i;

   // Control FSM: config latch, pop/accumulate counting, bias fetch, output handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_bphase    <= BP_REQ;
         r_in_ch     <= 11'd1;
         r_pops      <= 11'd0;
         r_acc_cnt   <= 11'd0;
         r_group_lim <= 12'd1;
         r_group     <= 12'd0;
         r_shift     <= 4'd0;
         r_pop_d     <= 1'b0;
         r_bias_req  <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else if (start_i) begin
         r_state     <= ST_ACCUM;
         r_bphase    <= BP_REQ;
         r_in_ch     <= (in_ch_limit_i == 10'd0) ? 11'd1 : {1'b0, in_ch_limit_i};
         r_group_lim <= (group_limit_i == 12'd0) ? 12'd1 : group_limit_i;
         r_shift     <= shift_i;
         r_pops      <= 11'd0;
         r_acc_cnt   <= 11'd0;
         r_group     <= 12'd0;
         r_pop_d     <= 1'b0;
         r_bias_req  <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_pop_d    <= w_rd_en;
         r_done     <= 1'b0;
         r_bias_req <= 1'b0;
         if (w_rd_en) begin
            r_pops <= r_pops + 11'd1;
         end
         case (r_state)
            ST_IDLE: begin
               r_out_valid <= 1'b0;
            end
            ST_ACCUM: begin
               if (r_pop_d) begin
                  r_acc_cnt <= r_acc_cnt + 11'd1;
                  if (r_acc_cnt == (r_in_ch - 11'd1)) begin
                     r_state  <= ST_BIAS;
                     r_bphase <= BP_REQ;
                  end
               end
            end
            ST_BIAS: begin
               case (r_bphase)
                  BP_REQ: begin
                     if (bias_ready_i) begin
                        r_bias_req <= 1'b1;
                        r_bphase   <= BP_WAIT;
                     end
                  end
                  BP_WAIT: begin
                     r_bphase <= BP_LOAD;
                  end
                  BP_LOAD: begin
                     r_bphase    <= BP_REQ;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_EMIT;
                  end
                  default: begin
                     r_bphase <= BP_REQ;
                  end
               endcase
            end
            ST_EMIT: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_pops      <= 11'd0;
                  r_acc_cnt   <= 11'd0;
                  if (r_group == (r_group_lim - 12'd1)) begin
                     r_group <= 12'd0;
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_group <= r_group + 12'd1;
                     r_state <= ST_ACCUM;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // First word of a group loads the accumulators, later words add.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_i) begin
         for (int k = 0; k < N_LANES; k++) begin
            r_acc_3x3[k] <= '0;
            r_acc_1x1[k] <= '0;
         end
      end else if ((r_state == ST_ACCUM) && r_pop_d) begin
         for (int k = 0; k < N_LANES; k++) begin
            if (r_acc_cnt == 11'd0) begin
               r_acc_3x3[k] <= lane_sext(fifo_exp_3x3_rd_data_i, k);
               r_acc_1x1[k] <= lane_sext(fifo_exp_1x1_rd_data_i, k);
            end else begin
               r_acc_3x3[k] <= r_acc_3x3[k] + lane_sext(fifo_exp_3x3_rd_data_i, k);
               r_acc_1x1[k] <= r_acc_1x1[k] + lane_sext(fifo_exp_1x1_rd_data_i, k);
            end
         end
      end else begin
         for (int k = 0; k < N_LANES; k++) begin
            r_acc_3x3[k] <= r_acc_3x3[k];
            r_acc_1x1[k] <= r_acc_1x1[k];
         end
      end
   end

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      logic signed [BIAS_W-1:0] w_bias_3x3;
      logic signed [BIAS_W-1:0] w_bias_1x1;

      assign w_bias_3x3 = bias_lane(bias_3x3_data_i, g);
      assign w_bias_1x1 = bias_lane(bias_1x1_data_i, g);

      exp_lane_requant u_rq_3x3 (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (w_lane_clr),
         .load_i  (w_lane_load),
         .acc_i   (r_acc_3x3[g]),
         .bias_i  (w_bias_3x3),
         .shift_i (r_shift),
         .q_o     (w_q_3x3[g])
      );

      exp_lane_requant u_rq_1x1 (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (w_lane_clr),
         .load_i  (w_lane_load),
         .acc_i   (r_acc_1x1[g]),
         .bias_i  (w_bias_1x1),
         .shift_i (r_shift),
         .q_o     (w_q_1x1[g])
      );
   end

   // Pack 3x3 lanes into the upper half and 1x1 lanes into the lower half.
   always_comb begin
      w_out_data = 64'd0;
      for (int k = 0; k < N_LANES; k++) begin
         w_out_data[32 + 8*k +: 8] = w_q_3x3[k];
         w_out_data[8*k +: 8]      = w_q_1x1[k];
      end
   end

   assign fifo_exp_3x3_rd_en_o = w_rd_en;
   assign fifo_exp_1x1_rd_en_o = w_rd_en;
   assign bias_req_o           = r_bias_req;
   assign out_valid_o          = r_out_valid;
   assign out_data_o           = w_out_data;
   assign done_o               = r_done;

endmodule

// File: tb/tb_expand_accum_relu.sv
// Directed bench for expand_accum_relu with simple non-FWFT FIFO models.
module tb_expand_accum_relu;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [9:0]  in_ch_limit_i;
   logic [11:0] group_limit_i;
   logic [3:0]  shift_i;
   logic [47:0] fifo_exp_3x3_rd_data_i = 48'd0;
   logic        fifo_exp_3x3_rd_en_o;
   logic        fifo_exp_3x3_empty_i;
   logic [47:0] fifo_exp_1x1_rd_data_i = 48'd0;
   logic        fifo_exp_1x1_rd_en_o;
   logic        fifo_exp_1x1_empty_i;
   logic        bias_req_o;
   logic        bias_ready_i;
   logic [63:0] bias_3x3_data_i;
   logic [63:0] bias_1x1_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] out_data_o;
   logic        done_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [47:0] mem3 [64];
   logic [47:0] mem1 [64];
   int          wr3 = 0, rd3 = 0, wr1 = 0, rd1 = 0;
   logic        stall1 = 1'b0;

   always #5 clk = ~clk;

   expand_accum_relu dut (
      .clk_i                  (clk),
      .rst_i                  (rst_i),
      .start_i                (start_i),
      .in_ch_limit_i          (in_ch_limit_i),
      .group_limit_i          (group_limit_i),
      .shift_i                (shift_i),
      .fifo_exp_3x3_rd_data_i (fifo_exp_3x3_rd_data_i),
      .fifo_exp_3x3_rd_en_o   (fifo_exp_3x3_rd_en_o),
      .fifo_exp_3x3_empty_i   (fifo_exp_3x3_empty_i),
      .fifo_exp_1x1_rd_data_i (fifo_exp_1x1_rd_data_i),
      .fifo_exp_1x1_rd_en_o   (fifo_exp_1x1_rd_en_o),
      .fifo_exp_1x1_empty_i   (fifo_exp_1x1_empty_i),
      .bias_req_o             (bias_req_o),
      .bias_ready_i           (bias_ready_i),
      .bias_3x3_data_i        (bias_3x3_data_i),
      .bias_1x1_data_i        (bias_1x1_data_i),
      .out_valid_o            (out_valid_o),
      .out_ready_i            (out_ready_i),
      .out_data_o             (out_data_o),
      .done_o                 (done_o)
   );

   assign fifo_exp_3x3_empty_i = (rd3 == wr3);
   assign fifo_exp_1x1_empty_i = (rd1 == wr1) || stall1;

   always @(posedge clk) begin
      if (fifo_exp_3x3_rd_en_o) begin
         fifo_exp_3x3_rd_data_i <= mem3[rd3[5:0]];
         rd3 <= rd3 + 1;
      end
      if (fifo_exp_1x1_rd_en_o) begin
         fifo_exp_1x1_rd_data_i <= mem1[rd1[5:0]];
         rd1 <= rd1 + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pop-protocol watch: pops always paired, never while either FIFO is empty.
   always @(negedge clk) begin
      if (!rst_i) begin
         check_eq("rd_en_pair", 64'(fifo_exp_3x3_rd_en_o), 64'(fifo_exp_1x1_rd_en_o));
         check_eq("pop_empty",
                  64'(fifo_exp_3x3_rd_en_o & (fifo_exp_3x3_empty_i | fifo_exp_1x1_empty_i)),
                  64'd0);
      end
   end

   function automatic logic [47:0] w4(input int l0, input int l1, input int l2, input int l3);
      return {l3[11:0], l2[11:0], l1[11:0], l0[11:0]};
   endfunction

   function automatic logic [63:0] b4(input int l0, input int l1, input int l2, input int l3);
      return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
   endfunction

   task automatic push(input logic [47:0] d3, input logic [47:0] d1);
      mem3[wr3[5:0]] = d3;
      wr3++;
      mem1[wr1[5:0]] = d1;
      wr1++;
   endtask

   task automatic start_layer(input int inch, input int grp, input int sh);
      @(negedge clk);
      in_ch_limit_i = inch[9:0];
      group_limit_i = grp[11:0];
      shift_i       = sh[3:0];
      start_i       = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [63:0] exp, input bit last, input int hold);
      for (int i = 0; i < 200; i++) begin
         if (out_valid_o) break;
         @(negedge clk);
      end
      check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd1);
      check_eq({tag, "_data"}, out_data_o, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 64'(out_valid_o), 64'd1);
         check_eq({tag, "_hold_data"}, out_data_o, exp);
         check_eq({tag, "_hold_nopop"}, 64'(fifo_exp_3x3_rd_en_o), 64'd0);
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      check_eq({tag, "_done"}, 64'(done_o), 64'(last));
      check_eq({tag, "_valid_drop"}, 64'(out_valid_o), 64'd0);
      if (last) begin
         @(negedge clk);
         check_eq({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      start_i         = 1'b0;
      in_ch_limit_i   = 10'd1;
      group_limit_i   = 12'd1;
      shift_i         = 4'd0;
      bias_ready_i    = 1'b1;
      bias_3x3_data_i = 64'd0;
      bias_1x1_data_i = 64'd0;
      out_ready_i     = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 64'(out_valid_o), 64'd0);
      check_eq("rst_done", 64'(done_o), 64'd0);
      check_eq("rst_data", out_data_o, 64'd0);
      check_eq("rst_rd_en", 64'(fifo_exp_3x3_rd_en_o), 64'd0);
      check_eq("rst_bias_req", 64'(bias_req_o), 64'd0);
      rst_i = 1'b0;
      @(negedge clk);

      // basic single channel, single group
      push(w4(12, 12, 12, 12), w4(5, 5, 5, 5));
      start_layer(1, 1, 0);
      expect_out("basic", 64'h0C0C0C0C_05050505, 1'b1, 0);

      // three channels, negative bias, shift 2
      bias_3x3_data_i = b4(-20, -20, -20, -20);
      bias_1x1_data_i = b4(-20, -20, -20, -20);
      push(w4(100, 100, 100, 100), w4(40, 80, 120, 160));
      push(w4(100, 100, 100, 100), w4(40, 80, 120, 160));
      push(w4(-50, -50, -50, -50), w4(40, 80, 120, 160));
      start_layer(3, 1, 2);
      expect_out("accum3", 64'h20202020_73553719, 1'b1, 0);

      // ReLU clamp and saturation boundaries
      bias_3x3_data_i = b4(10, 0, 10, 10);
      bias_1x1_data_i = 64'd0;
      push(w4(-20, 2000, 50, 0), w4(-100, 7, 128, 127));
      push(w4(-20, 2000, 50, 0), w4(-100, 7, 128, 128));
      start_layer(2, 1, 0);
      expect_out("relu_sat", 64'h0A6EFF00_FFFF0E00, 1'b1, 0);

      // 1x1 FIFO stalled for 5 cycles while 3x3 has data
      bias_3x3_data_i = b4(-20, -20, -20, -20);
      bias_1x1_data_i = b4(-20, -20, -20, -20);
      stall1 = 1'b1;
      push(w4(100, 100, 100, 100), w4(40, 80, 120, 160));
      push(w4(100, 100, 100, 100), w4(40, 80, 120, 160));
      push(w4(-50, -50, -50, -50), w4(40, 80, 120, 160));
      start_layer(3, 1, 2);
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_nopop", 64'(fifo_exp_3x3_rd_en_o), 64'd0);
         @(negedge clk);
      end
      stall1 = 1'b0;
      expect_out("stall", 64'h20202020_73553719, 1'b1, 0);

      // backpressure for 10 cycles with the next group already queued
      bias_3x3_data_i = 64'd0;
      bias_1x1_data_i = 64'd0;
      push(w4(12, 12, 12, 12), w4(5, 5, 5, 5));
      push(w4(300, 300, 300, 300), w4(1, 1, 1, 1));
      start_layer(1, 2, 0);
      expect_out("bp_g0", 64'h0C0C0C0C_05050505, 1'b0, 10);
      expect_out("bp_g1", 64'hFFFFFFFF_01010101, 1'b1, 0);

      // abort during group 2 of 4, then a fresh layer
      push(w4(3, 3, 3, 3), w4(1, 1, 1, 1));
      push(w4(4, 4, 4, 4), w4(1, 1, 1, 1));
      push(w4(10, 10, 10, 10), w4(0, 0, 0, 0));
      push(w4(20, 20, 20, 20), w4(0, 0, 0, 0));
      push(w4(99, 99, 99, 99), w4(99, 99, 99, 99));
      start_layer(2, 4, 0);
      expect_out("abort_g0", 64'h07070707_02020202, 1'b0, 0);
      expect_out("abort_g1", 64'h1E1E1E1E_00000000, 1'b0, 0);
      repeat (8) @(negedge clk);
      check_eq("abort_popped", 64'(rd3), 64'(wr3));
      start_layer(1, 1, 1);
      for (int i = 0; i < 6; i++) begin
         check_eq("abort_no_valid", 64'(out_valid_o), 64'd0);
         check_eq("abort_no_done", 64'(done_o), 64'd0);
         @(negedge clk);
      end
      push(w4(12, 12, 12, 12), w4(5, 5, 5, 5));
      expect_out("restart", 64'h06060606_02020202, 1'b1, 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
